// File: rtl/reg_dump_engine_pkg.sv
// Shared definitions for the register dump engine: FSM encoding, ASCII
// constants and row-layout helpers.
package reg_dump_engine_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_EMIT  = 2'd3;

    localparam logic [7:0] ASC_ZERO    = 8'h30;
    localparam logic [7:0] ASC_UPPER_A = 8'h41;
    localparam logic [7:0] ASC_X       = 8'h78;
    localparam logic [7:0] ASC_COLON   = 8'h3A;
    localparam logic [7:0] ASC_SPACE   = 8'h20;

    // Characters in the optional "xNN: " row prefix.
    localparam int LABEL_LEN = 5;

    function automatic int nib_count(input int data_width);
        return data_width / 4;
    endfunction

endpackage

// File: rtl/reg_dump_engine_nibble_to_ascii.sv
// One hex nibble to its uppercase ASCII digit.
module nibble_to_ascii
    import reg_dump_engine_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'.
    always_comb begin
        if (nib < 4'd10) ascii = ASC_ZERO + {4'b0000, nib};
        else             ascii = ASC_UPPER_A + {4'b0000, nib} - 8'd10;
    end

endmodule

// File: rtl/reg_dump_engine.sv
// Walks the register file and writes each register as a row of hex ASCII
// into the character buffer, optionally prefixed with a decimal "xNN: " label.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for start; rejects out-of-range single-reg requests
//   FETCH    | reg_addr presents the current row index to the register file
//   LATCH    | snapshot reg_data so later register writes cannot tear the row
//   EMIT     | one character per accepted write, label first, MS nibble first
module reg_dump_engine
    import reg_dump_engine_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_REGS   = 32,
    parameter int          RIDX_W     = 5,
    parameter int          ADDR_WIDTH = 13,
    parameter int          ROW_STRIDE = 80,
    parameter int          BASE_ADDR  = 0,
    parameter int          LABEL_EN   = 1,
    parameter logic [23:0] ATTR       = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [RIDX_W-1:0]     sel_reg,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [RIDX_W-1:0]     reg_addr,
    input  logic [DATA_WIDTH-1:0] reg_data,
    output logic                  char_wr_en,
    output logic [ADDR_WIDTH-1:0] char_wr_addr,
    output logic [31:0]           char_wr_data,
    input  logic                  char_wr_ready
);

    localparam int NIB   = nib_count(DATA_WIDTH);
    localparam int LBL   = LABEL_LEN * LABEL_EN;
    localparam int NCOL  = LBL + NIB;
    localparam int COL_W = $clog2(NCOL + 1);

    localparam logic [COL_W-1:0]  LBL_C      = COL_W'(LBL);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(NCOL - 1);
    localparam logic [RIDX_W-1:0] LAST_ROW   = RIDX_W'(NUM_REGS - 1);
    localparam logic [RIDX_W:0]   NUM_REGS_C = (RIDX_W + 1)'(NUM_REGS);

    state_t                  state;
    logic                    mode_q;
    logic [RIDX_W-1:0]       row;
    logic [COL_W-1:0]        col;
    logic [DATA_WIDTH-1:0]   snap;
    logic                    accept;
    logic [6:0]              row7;
    logic [6:0]              tens;
    logic [6:0]              ones;
    logic [7:0]              hex_ascii;
    logic [7:0]              ascii;
    logic [ADDR_WIDTH-1:0]   addr_calc;

    assign accept = (state == ST_EMIT) && char_wr_ready;

    // Sequencing: row/column walk, snapshot, done/err flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mode_q   <= 1'b0;
            row      <= '0;
            col      <= '0;
            snap     <= '0;
            reg_addr <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        if (mode && ({1'b0, sel_reg} >= NUM_REGS_C)) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            err      <= 1'b0;
                            row      <= mode ? sel_reg : '0;
                            reg_addr <= mode ? sel_reg : '0;
                            col      <= '0;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    snap  <= reg_data;
                    col   <= '0;
                    state <= ST_EMIT;
                end
                default: begin
                    if (accept) begin
                        // Hex columns consume the snapshot from the top nibble down.
                        if (col >= LBL_C) snap <= snap << 4;
                        if (col == LAST_COL) begin
                            col <= '0;
                            if (!mode_q && (row != LAST_ROW)) begin
                                row      <= row + 1'b1;
                                reg_addr <= row + 1'b1;
                                state    <= ST_FETCH;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Decimal label digits; the row index is always below 100.
    assign row7 = 7'(row);
    assign tens = row7 / 7'd10;
    assign ones = row7 % 7'd10;

    nibble_to_ascii u_hex (
        .nib   (snap[DATA_WIDTH-1 -: 4]),
        .ascii (hex_ascii)
    );

    // Character for the current column: label prefix, else the next hex digit.
    always_comb begin
        ascii = hex_ascii;
        if (col < LBL_C) begin
            case (col)
                COL_W'(0): ascii = ASC_X;
                COL_W'(1): ascii = ASC_ZERO + {1'b0, tens};
                COL_W'(2): ascii = ASC_ZERO + {1'b0, ones};
                COL_W'(3): ascii = ASC_COLON;
                default:   ascii = ASC_SPACE;
            endcase
        end
    end

    // Buffer address wraps naturally at 2^ADDR_WIDTH.
    assign addr_calc = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(row) * ADDR_WIDTH'(ROW_STRIDE)
                     + ADDR_WIDTH'(col);

    // Outputs are functions of held state only, so they stay put while stalled.
    assign busy         = (state != ST_IDLE);
    assign char_wr_en   = (state == ST_EMIT);
    assign char_wr_addr = char_wr_en ? addr_calc : '0;
    assign char_wr_data = char_wr_en ? {ascii, ATTR} : '0;

endmodule

// File: tb/tb_reg_dump_engine.sv
// Directed + randomized bench for reg_dump_engine; three instances cover the
// default layout, a 20-register file and a 16-bit unlabeled layout near the top
// of the buffer.
module tb_reg_dump_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: defaults
    logic        start_a, mode_a, busy_a, done_a, err_a, en_a, ready_a;
    logic [4:0]  sel_a, raddr_a;
    logic [31:0] rdata_a, wdata_a;
    logic [12:0] waddr_a;
    logic [31:0] regs_a [0:31];
    assign rdata_a = regs_a[raddr_a];

    // Instance B: NUM_REGS = 20
    logic        start_b, mode_b, busy_b, done_b, err_b, en_b, ready_b;
    logic [4:0]  sel_b, raddr_b;
    logic [31:0] rdata_b, wdata_b;
    logic [12:0] waddr_b;
    logic [31:0] regs_b [0:31];
    assign rdata_b = regs_b[raddr_b];

    // Instance C: 16-bit registers, no label, base 8000
    logic        start_c, mode_c, busy_c, done_c, err_c, en_c, ready_c;
    logic [4:0]  sel_c, raddr_c;
    logic [15:0] rdata_c;
    logic [31:0] wdata_c;
    logic [12:0] waddr_c;
    logic [15:0] regs_c [0:31];
    assign rdata_c = regs_c[raddr_c];

    reg_dump_engine dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .sel_reg(sel_a),
        .busy(busy_a), .done(done_a), .err(err_a), .reg_addr(raddr_a), .reg_data(rdata_a),
        .char_wr_en(en_a), .char_wr_addr(waddr_a), .char_wr_data(wdata_a),
        .char_wr_ready(ready_a));

    reg_dump_engine #(.NUM_REGS(20)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .sel_reg(sel_b),
        .busy(busy_b), .done(done_b), .err(err_b), .reg_addr(raddr_b), .reg_data(rdata_b),
        .char_wr_en(en_b), .char_wr_addr(waddr_b), .char_wr_data(wdata_b),
        .char_wr_ready(ready_b));

    reg_dump_engine #(.DATA_WIDTH(16), .LABEL_EN(0), .BASE_ADDR(8000)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .sel_reg(sel_c),
        .busy(busy_c), .done(done_c), .err(err_c), .reg_addr(raddr_c), .reg_data(rdata_c),
        .char_wr_en(en_c), .char_wr_addr(waddr_c), .char_wr_data(wdata_c),
        .char_wr_ready(ready_c));

    // Accepted writes, {addr, data}, per instance.
    logic [44:0] qa[$];
    logic [44:0] qb[$];
    logic [44:0] qc[$];
    bit          stall_a = 1'b0;
    logic [44:0] held_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Writes are accepted on the next rising edge; sample mid-cycle.
    always @(negedge clk) begin
        if (en_a && ready_a) qa.push_back({waddr_a, wdata_a});
        if (en_b && ready_b) qb.push_back({waddr_b, wdata_b});
        if (en_c && ready_c) qc.push_back({waddr_c, wdata_c});
        if (stall_a && en_a) chk("stall_hold_a", {19'd0, waddr_a, wdata_a}, {19'd0, held_a});
        stall_a = en_a && !ready_a;
        held_a  = {waddr_a, wdata_a};
    end

    function automatic logic [7:0] exp_char(input int row, input int col,
                                             input logic [31:0] val, input int nib,
                                             input int lbl);
        int n;
        if (col < lbl) begin
            case (col)
                0:       return 8'h78;
                1:       return 8'(8'h30 + row / 10);
                2:       return 8'(8'h30 + row % 10);
                3:       return 8'h3A;
                default: return 8'h20;
            endcase
        end
        n = int'((val >> (4 * (nib - 1 - (col - lbl)))) & 32'hF);
        return (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
    endfunction

    function automatic int qsize(input int inst);
        case (inst)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic logic done_of(input int inst);
        case (inst)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic busy_of(input int inst);
        case (inst)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    // Compare the next row's worth of captured writes with the expected text.
    task automatic check_row(input int inst, input int row, input logic [31:0] val);
        int nib  = (inst == 2) ? 4 : 8;
        int lbl  = (inst == 2) ? 0 : 5;
        int base = (inst == 2) ? 8000 : 0;
        logic [44:0] e;
        for (int c = 0; c < lbl + nib; c++) begin
            if (qsize(inst) == 0) begin
                chk($sformatf("writes_left_i%0d_r%0d", inst, row), 64'(qsize(inst)),
                    64'(lbl + nib - c));
                return;
            end
            case (inst)
                0:       e = qa.pop_front();
                1:       e = qb.pop_front();
                default: e = qc.pop_front();
            endcase
            chk($sformatf("addr_i%0d_r%0d_c%0d", inst, row, c), 64'(e[44:32]),
                64'((base + row * 80 + c) % 8192));
            chk($sformatf("char_i%0d_r%0d_c%0d", inst, row, c), 64'(e[31:24]),
                64'(exp_char(row, c, val, nib, lbl)));
            chk($sformatf("attr_i%0d_r%0d_c%0d", inst, row, c), 64'(e[23:0]), 64'h00FFFFFF);
        end
    endtask

    task automatic start_dump(input int inst, input logic m, input logic [4:0] s);
        @(posedge clk); #1;
        case (inst)
            0:       begin start_a = 1'b1; mode_a = m; sel_a = s; end
            1:       begin start_b = 1'b1; mode_b = m; sel_b = s; end
            default: begin start_c = 1'b1; mode_c = m; sel_c = s; end
        endcase
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    // k = rising edges after the start edge until done is visible.
    // rmode (instance A): 0 ready high, 1 ready alternating, 2 random ready.
    // poke_at >= 0 pulses start on A at that point; the engine must ignore it.
    task automatic wait_done(input int inst, input int budget, input int rmode,
                             input int poke_at, output int k);
        k = 0;
        while (!done_of(inst) && k < budget) begin
            if (inst == 0) begin
                case (rmode)
                    0:       ready_a = 1'b1;
                    1:       ready_a = (k % 2 == 1);
                    default: ready_a = 1'($urandom % 2);
                endcase
                if (k == poke_at) begin start_a = 1'b1; mode_a = 1'b1; sel_a = 5'd0; end
                else start_a = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        ready_a = 1'b1;
        start_a = 1'b0;
        chk($sformatf("done_seen_i%0d", inst), 64'(done_of(inst)), 64'd1);
        chk($sformatf("busy_at_done_i%0d", inst), 64'(busy_of(inst)), 64'd0);
    endtask

    task automatic check_a_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_done"}, 64'(done_a), 64'd0);
        chk({tag, "_err"},  64'(err_a),  64'd0);
        chk({tag, "_en"},   64'(en_a),   64'd0);
        chk({tag, "_addr"}, 64'(waddr_a), 64'd0);
        chk({tag, "_data"}, 64'(wdata_a), 64'd0);
        chk({tag, "_raddr"}, 64'(raddr_a), 64'd0);
    endtask

    initial begin
        int          k;
        int          kk;
        int          sel;
        bit          seen;
        logic [15:0] v16;

        rst = 1'b1;
        start_a = 1'b0; mode_a = 1'b0; sel_a = '0; ready_a = 1'b1;
        start_b = 1'b0; mode_b = 1'b0; sel_b = '0; ready_b = 1'b1;
        start_c = 1'b0; mode_c = 1'b0; sel_c = '0; ready_c = 1'b1;
        for (int i = 0; i < 32; i++) begin
            regs_a[i] = $urandom;
            regs_b[i] = $urandom;
            regs_c[i] = 16'($urandom);
        end
        repeat (3) @(posedge clk);
        #1;
        check_a_zero("reset");
        chk("reset_en_b", 64'(en_b), 64'd0);
        chk("reset_done_c", 64'(done_c), 64'd0);
        rst = 1'b0;

        // Single register, label on
        regs_a[5] = 32'hDEADBEEF;
        start_dump(0, 1'b1, 5'd5);
        chk("busy_after_start", 64'(busy_a), 64'd1);
        wait_done(0, 100, 0, -1, k);
        chk("lat_single", 64'(k), 64'd15);
        chk("err_single", 64'(err_a), 64'd0);
        check_row(0, 5, 32'hDEADBEEF);
        chk("extra_single", 64'(qa.size()), 64'd0);

        // Full dump
        for (int i = 0; i < 32; i++) regs_a[i] = 32'(i) * 32'h11111111;
        start_dump(0, 1'b0, 5'd7);
        wait_done(0, 600, 0, -1, k);
        chk("lat_full", 64'(k), 64'd480);
        for (int i = 0; i < 32; i++) check_row(0, i, 32'(i) * 32'h11111111);
        chk("extra_full", 64'(qa.size()), 64'd0);

        // Alternating backpressure
        sel = $urandom_range(0, 31);
        regs_a[sel] = $urandom;
        start_dump(0, 1'b1, 5'(sel));
        wait_done(0, 100, 1, -1, k);
        chk("lat_toggle", 64'(k), 64'd28);
        chk("count_toggle", 64'(qa.size()), 64'd13);
        check_row(0, sel, regs_a[sel]);

        // Out-of-range select, then the last valid index
        start_dump(1, 1'b1, 5'd31);
        chk("bad_done", 64'(done_b), 64'd1);
        chk("bad_err", 64'(err_b), 64'd1);
        chk("bad_busy", 64'(busy_b), 64'd0);
        @(posedge clk); #1;
        chk("bad_done_pulse", 64'(done_b), 64'd0);
        chk("bad_err_held", 64'(err_b), 64'd1);
        chk("bad_no_writes", 64'(qb.size()), 64'd0);
        start_dump(1, 1'b1, 5'd19);
        chk("err_cleared", 64'(err_b), 64'd0);
        wait_done(1, 100, 0, -1, k);
        chk("lat_b19", 64'(k), 64'd15);
        check_row(1, 19, regs_b[19]);
        chk("extra_b", 64'(qb.size()), 64'd0);

        // Reset during row 3 of a full dump
        for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
        start_dump(0, 1'b0, 5'd0);
        repeat (50) begin @(posedge clk); #1; end
        chk("row3_raddr", 64'(raddr_a), 64'd3);
        rst = 1'b1;
        #1;
        check_a_zero("abort");
        @(posedge clk); #1;
        chk("abort_busy_held", 64'(busy_a), 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (done_a) seen = 1'b1; end
        chk("no_stale_done", 64'(seen), 64'd0);
        qa.delete();

        // Restart; a start pulse mid-dump must not disturb it
        for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
        start_dump(0, 1'b0, 5'd0);
        wait_done(0, 600, 0, 100, k);
        chk("lat_restart", 64'(k), 64'd480);
        chk("count_restart", 64'(qa.size()), 64'd416);
        for (int i = 0; i < 32; i++) check_row(0, i, regs_a[i]);

        // 16-bit, no label, snapshot isolation
        regs_c[2] = 16'h0A5F;
        start_dump(2, 1'b1, 5'd2);
        kk = 0;
        while (!en_c && kk < 10) begin @(posedge clk); #1; kk++; end
        chk("c_emit_seen", 64'(en_c), 64'd1);
        regs_c[2] = 16'h1234;
        wait_done(2, 50, 0, -1, k);
        chk("lat_c", 64'(k + kk), 64'd6);
        check_row(2, 2, 32'h0000_0A5F);

        // Row 3 crosses the end of the buffer
        v16 = 16'($urandom);
        regs_c[3] = v16;
        start_dump(2, 1'b1, 5'd3);
        wait_done(2, 50, 0, -1, k);
        check_row(2, 3, {16'd0, v16});
        chk("extra_c", 64'(qc.size()), 64'd0);

        // Random single-register dumps under random backpressure
        for (int t = 0; t < 4; t++) begin
            sel = $urandom_range(0, 31);
            regs_a[sel] = $urandom;
            start_dump(0, 1'b1, 5'(sel));
            wait_done(0, 300, 2, -1, k);
            check_row(0, sel, regs_a[sel]);
            chk("extra_rand", 64'(qa.size()), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
